dm_responder: RTL and testbench

Multi-cycle data-memory responder serving the DM stage of the 4-stage pipelined processor. Accepts the pipeline's load/store requests (mem_read, wen, addr, data_in), completes stores in one cycle, and returns loads after a fixed programmable latency. While a load is outstanding it drives `stall` so the pipeline freezes. It replaces the single-cycle data_memory model on the responder side of the DM interface.

---
 rtl/dm_responder_pkg.sv | 6 +
 rtl/dm_array.sv | 19 +
 rtl/dm_responder.sv | 66 ++++++
 tb/tb_dm_responder.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/dm_responder_pkg.sv
// dm_responder_pkg: shared word width, FSM encodings and default load latency.
package dm_responder_pkg;
    localparam int DSIZE_DEF = 16;
    localparam int RD_LAT_DEF = 2;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/dm_array.sv
// dm_array: data storage with synchronous write and asynchronous read.
module dm_array
    import dm_responder_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int AW = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [DSIZE-1:0] rdata
);
    logic [DSIZE-1:0] mem [2**AW];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/dm_responder.sv
// dm_responder: multi-cycle data-memory responder; single-cycle stores, fixed-latency loads with pipeline stall.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int AW = 8,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             wen,
    input  logic [15:0]      addr,
    input  logic [DSIZE-1:0] data_in,
    output logic [DSIZE-1:0] data_out,
    output logic             rvalid,
    output logic             stall,
    output logic             err
);
    localparam logic [3:0] CNT_INIT = 4'(RD_LAT > 1 ? RD_LAT - 2 : 0);
    state_t state, next_state;
    logic [3:0] cnt;
    logic [AW-1:0] laddr;
    logic loor, oor, load, we;
    logic [DSIZE-1:0] rdata, rd_resp, data_hold;
    assign oor = addr[15:AW] != '0;
    assign load = mem_read & ~wen;
    assign we = state == IDLE && wen && !mem_read && !oor;
    // Out-of-range loads still run the full latency but return zero.
    assign rd_resp = loor ? '0 : rdata;
    dm_array #(.DSIZE(DSIZE), .AW(AW)) u_array (
        .clk(clk),
        .we(we),
        .waddr(addr[AW-1:0]),
        .wdata(data_in),
        .raddr(laddr),
        .rdata(rdata)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            laddr <= '0;
            loor <= 1'b0;
            data_hold <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && load) begin
                laddr <= addr[AW-1:0];
                loor <= oor;
                cnt <= CNT_INIT;
            end else if (state == WAIT && cnt != '0) cnt <= cnt - 4'd1;
            if (state == RESP) data_hold <= rd_resp;
        end
    always_comb begin
        next_state = IDLE;
        if (state == IDLE) next_state = load ? (RD_LAT == 1 ? RESP : WAIT) : IDLE;
        else if (state == WAIT) next_state = cnt == '0 ? RESP : WAIT;
    end
    always_comb begin
        rvalid = state == RESP;
        stall = (state == IDLE && load) || state == WAIT;
        data_out = rvalid ? rd_resp : data_hold;
        err = (state == IDLE && wen && (mem_read || oor)) || (rvalid && loor);
    end
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed checks of three responders (RD_LAT 1/2/3) sharing one request bus.
module tb_dm_responder;
    logic clk = 1'b0, rst = 1'b1, mem_read = 1'b0, wen = 1'b0;
    logic [15:0] addr = '0, data_in = '0;
    logic [15:0] d1, d2, d3;
    logic v1, v2, v3, s1, s2, s3, e1, e2, e3;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    dm_responder #(.DSIZE(16), .AW(8), .RD_LAT(1)) u1 (.clk(clk), .rst(rst), .mem_read(mem_read), .wen(wen),
        .addr(addr), .data_in(data_in), .data_out(d1), .rvalid(v1), .stall(s1), .err(e1));
    dm_responder #(.DSIZE(16), .AW(8), .RD_LAT(2)) u2 (.clk(clk), .rst(rst), .mem_read(mem_read), .wen(wen),
        .addr(addr), .data_in(data_in), .data_out(d2), .rvalid(v2), .stall(s2), .err(e2));
    dm_responder #(.DSIZE(16), .AW(8), .RD_LAT(3)) u3 (.clk(clk), .rst(rst), .mem_read(mem_read), .wen(wen),
        .addr(addr), .data_in(data_in), .data_out(d3), .rvalid(v3), .stall(s3), .err(e3));
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic mid();
        @(negedge clk);
    endtask
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        mem_read = r;
        wen = w;
        addr = a;
        data_in = d;
    endtask
    task automatic idle(input int n);
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        repeat (n) tick();
    endtask
    task automatic store(input logic [15:0] a, input logic [15:0] d);
        drive(1'b0, 1'b1, a, d);
        tick();
    endtask
    initial begin
        tick();
        tick();
        mid();
        chk("rst_stall", {15'd0, s2}, 16'd0);
        chk("rst_rvalid", {15'd0, v2}, 16'd0);
        chk("rst_err", {15'd0, e2}, 16'd0);
        chk("rst_data", d2, 16'h0000);
        tick();
        rst = 1'b0;
        tick();
        drive(1'b0, 1'b1, 16'd5, 16'hBEEF);
        mid();
        chk("store_stall", {15'd0, s2}, 16'd0);
        chk("store_err", {15'd0, e2}, 16'd0);
        tick();
        drive(1'b1, 1'b0, 16'd5, 16'h0);
        for (int c = 0; c < 3; c++) begin
            mid();
            chk($sformatf("lat2_stall_c%0d", c), {15'd0, s2}, {15'd0, c < 2});
            chk($sformatf("lat2_rvalid_c%0d", c), {15'd0, v2}, {15'd0, c == 2});
            tick();
        end
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        // Response data must hold after the rvalid pulse.
        mid();
        chk("lat2_hold", d2, 16'hBEEF);
        chk("lat2_rvalid_off", {15'd0, v2}, 16'd0);
        idle(5);
        store(16'd3, 16'h1234);
        drive(1'b1, 1'b0, 16'd3, 16'h0);
        mid();
        chk("lat1_stall", {15'd0, s1}, 16'd1);
        chk("lat1_rvalid0", {15'd0, v1}, 16'd0);
        tick();
        mid();
        chk("lat1_stall_resp", {15'd0, s1}, 16'd0);
        chk("lat1_rvalid", {15'd0, v1}, 16'd1);
        chk("lat1_raw_data", d1, 16'h1234);
        tick();
        idle(5);
        store(16'd1, 16'h0011);
        store(16'd2, 16'h0022);
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 1'b0, c < 4 ? 16'd1 : 16'd2, 16'h0);
            mid();
            chk($sformatf("b2b_rvalid_c%0d", c), {15'd0, v3}, {15'd0, c == 3 || c == 7});
            chk($sformatf("b2b_stall_c%0d", c), {15'd0, s3}, {15'd0, c != 3 && c != 7});
            if (c >= 3) chk($sformatf("b2b_data_c%0d", c), d3, c < 7 ? 16'h0011 : 16'h0022);
            tick();
        end
        idle(5);
        store(16'd7, 16'h0777);
        drive(1'b1, 1'b1, 16'd7, 16'hFFFF);
        mid();
        chk("both_err", {15'd0, e2}, 16'd1);
        chk("both_stall", {15'd0, s2}, 16'd0);
        tick();
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        mid();
        chk("both_err_off", {15'd0, e2}, 16'd0);
        tick();
        drive(1'b1, 1'b0, 16'd7, 16'h0);
        tick();
        tick();
        mid();
        chk("both_nowrite_v", {15'd0, v2}, 16'd1);
        chk("both_nowrite_d", d2, 16'h0777);
        tick();
        idle(5);
        store(16'h0000, 16'h5A5A);
        drive(1'b1, 1'b0, 16'h0100, 16'h0);
        for (int c = 0; c < 3; c++) begin
            mid();
            chk($sformatf("oor_err_c%0d", c), {15'd0, e2}, {15'd0, c == 2});
            chk($sformatf("oor_rvalid_c%0d", c), {15'd0, v2}, {15'd0, c == 2});
            if (c == 2) chk("oor_data", d2, 16'h0000);
            tick();
        end
        idle(5);
        drive(1'b0, 1'b1, 16'h0100, 16'hABCD);
        mid();
        chk("oor_store_err", {15'd0, e2}, 16'd1);
        chk("oor_store_stall", {15'd0, s2}, 16'd0);
        tick();
        drive(1'b1, 1'b0, 16'h0000, 16'h0);
        tick();
        tick();
        mid();
        chk("oor_alias_v", {15'd0, v2}, 16'd1);
        chk("oor_alias_d", d2, 16'h5A5A);
        tick();
        idle(5);
        drive(1'b1, 1'b0, 16'd5, 16'h0);
        tick();
        mid();
        chk("mid_wait_stall", {15'd0, s2}, 16'd1);
        #1;
        rst = 1'b1;
        mem_read = 1'b0;
        #1;
        chk("async_rst_stall", {15'd0, s2}, 16'd0);
        chk("async_rst_rvalid", {15'd0, v2}, 16'd0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            mid();
            chk($sformatf("abandon_rvalid_c%0d", c), {15'd0, v2}, 16'd0);
            tick();
        end
        drive(1'b1, 1'b0, 16'd5, 16'h0);
        tick();
        tick();
        mid();
        chk("post_rst_v", {15'd0, v2}, 16'd1);
        chk("post_rst_d", d2, 16'hBEEF);
        tick();
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
